traffic_timebase: RTL and testbench

Timebase and pedestrian-input stage that sits directly upstream of the traffic light controller. It debounces the raw pedestrian button into a single-cycle `pass` pulse. It also provides the free-running 11-bit `count` that the controller compares against its phase durations. The controller's `recount` output loops back here to restart the count at every phase change.

---
 rtl/traffic_timebase_if.sv | 25 ++
 rtl/traffic_timebase.sv | 140 ++++++++++++++
 tb/tb_traffic_timebase.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/traffic_timebase_if.sv
// Bundle between the traffic timebase and the light controller it feeds.
// The controller uses the master side and the timebase uses the slave side.
interface traffic_timebase_if;
  logic        btn_raw;
  logic        recount;
  logic [10:0] count;
  logic        pass;
  logic        sat;

  modport master (
    output btn_raw,
    output recount,
    input  count,
    input  pass,
    input  sat
  );

  modport slave (
    input  btn_raw,
    input  recount,
    output count,
    output pass,
    output sat
  );
endinterface

// File: rtl/traffic_timebase.sv
// Pedestrian button debounce/pulse stage plus the saturating phase timebase.
// Optional pass lockout window is enabled by defining TRAFFIC_PASS_LOCKOUT_EN.
module traffic_timebase #(
  parameter int unsigned PRESCALE     = 1,
  parameter int unsigned DEBOUNCE_LEN = 4,
  parameter int unsigned LOCKOUT_CYC  = 2048
) (
  input logic               clk_i,
  input logic               rst_ni,
  traffic_timebase_if.slave bus
);

  localparam logic [15:0] PreLast  = 16'(PRESCALE - 1);
  localparam logic [7:0]  DbcLast  = 8'(DEBOUNCE_LEN - 1);
  localparam logic [10:0] CountMax = 11'h7FF;

  logic        sync1_q;
  logic        sync2_q;
  logic        db_q;
  logic        db_d;
  logic [7:0]  dbCnt_q;
  logic [7:0]  dbCnt_d;
  logic        dbDly_q;
  logic        dbRise;
  logic        pass_q;
  logic        pass_d;
  logic [15:0] preCnt_q;
  logic [15:0] preCnt_d;
  logic [10:0] count_q;
  logic [10:0] count_d;
  logic        sat_q;
  logic        sat_d;
  logic        tick;

  // Two-flop synchronizer; only the second stage feeds the debouncer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    db_d    = db_q;
    dbCnt_d = dbCnt_q;
    if (sync2_q == db_q) begin
      dbCnt_d = '0;
    end else if (dbCnt_q == DbcLast) begin
      db_d    = sync2_q;
      dbCnt_d = '0;
    end else begin
      dbCnt_d = dbCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q    <= 1'b0;
      dbCnt_q <= '0;
      dbDly_q <= 1'b0;
    end else begin
      db_q    <= db_d;
      dbCnt_q <= dbCnt_d;
      dbDly_q <= db_q;
    end
  end

  // Rising edge of the registered level, so pass lands one edge after db flips.
  assign dbRise = db_q & ~dbDly_q;

`ifdef TRAFFIC_PASS_LOCKOUT_EN
  localparam int unsigned LockW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [LockW-1:0] LockLoad = LockW'(LOCKOUT_CYC - 1);

  logic [LockW-1:0] lockCnt_q;
  logic [LockW-1:0] lockCnt_d;

  always_comb begin
    pass_d    = dbRise && (lockCnt_q == '0);
    lockCnt_d = lockCnt_q;
    if (pass_d) begin
      lockCnt_d = LockLoad;
    end else if (lockCnt_q != '0) begin
      lockCnt_d = lockCnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lockCnt_q <= '0;
    end else begin
      lockCnt_q <= lockCnt_d;
    end
  end
`else
  logic unusedLockout;
  assign unusedLockout = ^LOCKOUT_CYC;
  assign pass_d        = dbRise;
`endif

  assign tick = (preCnt_q == PreLast);

  // Restart beats a coincident tick; the count saturates rather than wrapping.
  always_comb begin
    preCnt_d = preCnt_q + 16'd1;
    count_d  = count_q;
    if (bus.recount) begin
      preCnt_d = '0;
      count_d  = '0;
    end else if (tick) begin
      preCnt_d = '0;
      if (count_q != CountMax) begin
        count_d = count_q + 11'd1;
      end
    end
    sat_d = (count_d == CountMax);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      preCnt_q <= '0;
      count_q  <= '0;
      sat_q    <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      preCnt_q <= preCnt_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
      pass_q   <= pass_d;
    end
  end

  assign bus.count = count_q;
  assign bus.pass  = pass_q;
  assign bus.sat   = sat_q;

endmodule

// File: tb/tb_traffic_timebase.sv
// Directed bench for traffic_timebase: reset, debounce, restart, saturation,
// prescale and pass lockout (expectation follows TRAFFIC_PASS_LOCKOUT_EN).
module tb_traffic_timebase;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   passSeen   = 0;

  traffic_timebase_if busA ();
  traffic_timebase_if busB ();

  traffic_timebase #(
    .PRESCALE    (1),
    .DEBOUNCE_LEN(4),
    .LOCKOUT_CYC (100)
  ) dutA (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (busA)
  );

  traffic_timebase #(
    .PRESCALE    (3),
    .DEBOUNCE_LEN(4),
    .LOCKOUT_CYC (100)
  ) dutB (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (busB)
  );

  always #5 clk = ~clk;

  task automatic tickClk();
    @(posedge clk);
    #1;
    if (busA.pass === 1'b1) passSeen++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic btn, input int cycles);
    busA.btn_raw = btn;
    repeat (cycles) tickClk();
  endtask

  initial begin
    int expPasses;
`ifdef TRAFFIC_PASS_LOCKOUT_EN
    expPasses = 1;
`else
    expPasses = 2;
`endif
    rst_n        = 1'b0;
    busA.btn_raw = 1'b0;
    busA.recount = 1'b0;
    busB.btn_raw = 1'b0;
    busB.recount = 1'b0;

    #2;
    checkOutput("rst_countA", 32'(busA.count), 0);
    checkOutput("rst_passA", 32'(busA.pass), 0);
    checkOutput("rst_satA", 32'(busA.sat), 0);
    checkOutput("rst_countB", 32'(busB.count), 0);
    rst_n = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      tickClk();
      checkOutput("count_after_rst", 32'(busA.count), 32'(i));
    end

    repeat (295) tickClk();
    checkOutput("count_300", 32'(busA.count), 300);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_count", 32'(busA.count), 0);
    checkOutput("async_rst_pass", 32'(busA.pass), 0);
    checkOutput("async_rst_sat", 32'(busA.sat), 0);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tickClk();
      checkOutput("count_after_async_rst", 32'(busA.count), 32'(i));
    end

    repeat (1018) tickClk();
    checkOutput("count_1023", 32'(busA.count), 1023);
    busA.recount = 1'b1;
    tickClk();
    checkOutput("recount_zero", 32'(busA.count), 0);
    busA.recount = 1'b0;
    tickClk();
    checkOutput("recount_resume", 32'(busA.count), 1);

    busA.recount = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tickClk();
      checkOutput("recount_hold", 32'(busA.count), 0);
    end
    busA.recount = 1'b0;
    tickClk();
    checkOutput("recount_hold_rel1", 32'(busA.count), 1);
    tickClk();
    checkOutput("recount_hold_rel2", 32'(busA.count), 2);

    // Glitch of 3 samples, gap of 2, then a clean press
    busA.btn_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tickClk();
      checkOutput("glitch_high_pass", 32'(busA.pass), 0);
    end
    busA.btn_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tickClk();
      checkOutput("glitch_low_pass", 32'(busA.pass), 0);
    end
    busA.btn_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tickClk();
      checkOutput("press_pass", 32'(busA.pass), (i == 7) ? 1 : 0);
    end
    passSeen = 0;
    applyStimulus(1'b0, 120);
    checkOutput("release_no_pass", passSeen, 0);

    passSeen = 0;
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 40);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 130);
    checkOutput("presses_50_apart", passSeen, 32'(expPasses));

    passSeen = 0;
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 140);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 130);
    checkOutput("presses_150_apart", passSeen, 2);

    busA.recount = 1'b1;
    tickClk();
    busA.recount = 1'b0;
    checkOutput("sat_start_count", 32'(busA.count), 0);
    checkOutput("sat_start_sat", 32'(busA.sat), 0);
    repeat (2046) tickClk();
    checkOutput("count_2046", 32'(busA.count), 2046);
    checkOutput("sat_low_2046", 32'(busA.sat), 0);
    tickClk();
    checkOutput("count_2047", 32'(busA.count), 2047);
    checkOutput("sat_high_2047", 32'(busA.sat), 1);
    repeat (60) tickClk();
    checkOutput("count_hold_2047", 32'(busA.count), 2047);
    checkOutput("sat_hold", 32'(busA.sat), 1);

    busB.recount = 1'b1;
    tickClk();
    busB.recount = 1'b0;
    checkOutput("pre_recount", 32'(busB.count), 0);
    for (int i = 1; i <= 30; i++) begin
      tickClk();
      checkOutput("prescale_count", 32'(busB.count), 32'(i / 3));
    end
    repeat (2) tickClk();
    checkOutput("prescale_hold", 32'(busB.count), 10);
    // This edge would also tick; restart must win
    busB.recount = 1'b1;
    tickClk();
    checkOutput("recount_vs_tick", 32'(busB.count), 0);
    busB.recount = 1'b0;
    repeat (2) tickClk();
    checkOutput("prescale_restart_wait", 32'(busB.count), 0);
    tickClk();
    checkOutput("prescale_restart_tick", 32'(busB.count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
